// File: rtl/operand_stack.sv
// Operand stack with registered top-of-stack (TOS) and next-on-stack (NOS).
// TOS and NOS are held in registers, so the caller can read the current TOS
// in the same cycle it asserts pop. The storage array is never cleared.
// Stale entries cannot reach the outputs, because NOS is only reloaded from
// the array while at least two words remain.
//
// Operation semantics (there is no handshake; every sampled edge acts):
//   push only, not full : write data_in at sp, TOS <= data_in, NOS <= old TOS
//   push only, full     : nothing changes, overflow set
//   pop only, not empty : TOS <= old NOS, NOS <= array[sp-3] (or 0)
//   pop only, empty     : nothing changes, underflow set
//   push + pop, !empty  : TOS replaced by data_in, count and NOS unchanged
//   push + pop, empty   : treated as push only, underflow set
// The error flags are sticky. When clear_err and a new error occur together,
// the new error wins.
module operand_stack #(
   parameter int WIDTH_DATA = 32,
   parameter int DEPTH      = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH_DATA-1:0]      data_in,
   input  logic                       clear_err,
   output logic [WIDTH_DATA-1:0]      data_out,
   output logic [WIDTH_DATA-1:0]      next_out,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty,
   output logic                       overflow,
   output logic                       underflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH_DATA-1:0] r_mem [DEPTH];
   logic [CW-1:0]         r_count;
   logic [WIDTH_DATA-1:0] r_tos;
   logic [WIDTH_DATA-1:0] r_nos;
   logic                  r_ovf;
   logic                  r_unf;

   logic                  w_empty;
   logic                  w_full;
   logic                  w_do_push;
   logic                  w_do_pop;
   logic                  w_do_repl;
   logic                  w_ovf_evt;
   logic                  w_unf_evt;
   logic                  w_mem_we;
   logic [AW-1:0]         w_wr_idx;
   logic [AW-1:0]         w_rd3_idx;
   logic [WIDTH_DATA-1:0] w_rd3_data;

   // Decode the requested operation against the current occupancy.
   always_comb begin
      w_empty    = (r_count == '0);
      w_full     = (r_count == CW'(DEPTH));
      w_do_push  = push && (!pop || w_empty) && !w_full;
      w_do_pop   = pop && !push && !w_empty;
      w_do_repl  = push && pop && !w_empty;
      w_ovf_evt  = push && !pop && w_full;
      w_unf_evt  = pop && w_empty;
      w_mem_we   = !rst && (w_do_push || w_do_repl);
      w_wr_idx   = w_do_push ? AW'(r_count) : AW'(r_count - CW'(1));
      w_rd3_idx  = AW'(r_count - CW'(3));
      w_rd3_data = (r_count >= CW'(3)) ? r_mem[w_rd3_idx] : '0;
   end

   // Storage array write. It has no reset, because stale data is never exposed.
   always_ff @(posedge clk) begin
      if (w_mem_we) begin
         r_mem[w_wr_idx] <= data_in;
      end
   end

   // Pointer, registered TOS/NOS and sticky error flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= '0;
         r_tos   <= '0;
         r_nos   <= '0;
         r_ovf   <= 1'b0;
         r_unf   <= 1'b0;
      end else begin
         if (w_do_push) begin
            r_count <= r_count + CW'(1);
            r_tos   <= data_in;
            r_nos   <= r_tos;
         end else if (w_do_pop) begin
            r_count <= r_count - CW'(1);
            r_tos   <= r_nos;
            r_nos   <= w_rd3_data;
         end else if (w_do_repl) begin
            r_tos   <= data_in;
         end
         if (w_ovf_evt) begin
            r_ovf <= 1'b1;
         end else if (clear_err) begin
            r_ovf <= 1'b0;
         end
         if (w_unf_evt) begin
            r_unf <= 1'b1;
         end else if (clear_err) begin
            r_unf <= 1'b0;
         end
      end
   end

   assign data_out  = r_tos;
   assign next_out  = r_nos;
   assign count     = r_count;
   assign full      = w_full;
   assign empty     = w_empty;
   assign overflow  = r_ovf;
   assign underflow = r_unf;

endmodule

// File: tb/tb_operand_stack.sv
// Directed and random stimulus for operand_stack. A behavioural stack model
// predicts each cycle's outputs. The predictions are queued when stimulus is
// driven, then popped and compared after the DUT updates.
module tb_operand_stack;

   localparam int W  = 32;
   localparam int D  = 16;
   localparam int CW = $clog2(D) + 1;

   typedef struct packed {
      logic [W-1:0]  tos;
      logic [W-1:0]  nos;
      logic [CW-1:0] cnt;
      logic          full;
      logic          empty;
      logic          ovf;
      logic          unf;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          push;
   logic          pop;
   logic [W-1:0]  data_in;
   logic          clear_err;
   logic [W-1:0]  data_out;
   logic [W-1:0]  next_out;
   logic [CW-1:0] count;
   logic          full;
   logic          empty;
   logic          overflow;
   logic          underflow;

   exp_t          exp_q[$];
   logic [W-1:0]  m_stk[$];
   logic          m_ovf;
   logic          m_unf;
   int            n_checks;
   int            n_pass;

   operand_stack #(.WIDTH_DATA(W), .DEPTH(D)) dut (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .pop       (pop),
      .data_in   (data_in),
      .clear_err (clear_err),
      .data_out  (data_out),
      .next_out  (next_out),
      .count     (count),
      .full      (full),
      .empty     (empty),
      .overflow  (overflow),
      .underflow (underflow)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
      $fatal(1, "watchdog");
   end

   // behavioural model: apply one cycle's inputs
   task automatic model_apply(input logic r, input logic pu, input logic po,
                              input logic [W-1:0] din, input logic clr);
      logic oe;
      logic ue;
      oe = 1'b0;
      ue = 1'b0;
      if (r) begin
         m_stk.delete();
         m_ovf = 1'b0;
         m_unf = 1'b0;
      end else begin
         if (pu && po) begin
            if (m_stk.size() > 0) m_stk[m_stk.size()-1] = din;
            else begin
               m_stk.push_back(din);
               ue = 1'b1;
            end
         end else if (pu) begin
            if (m_stk.size() < D) m_stk.push_back(din);
            else oe = 1'b1;
         end else if (po) begin
            if (m_stk.size() > 0) void'(m_stk.pop_back());
            else ue = 1'b1;
         end
         m_ovf = oe ? 1'b1 : (clr ? 1'b0 : m_ovf);
         m_unf = ue ? 1'b1 : (clr ? 1'b0 : m_unf);
      end
   endtask

   function automatic exp_t model_expect();
      exp_t e;
      int   n;
      n       = m_stk.size();
      e.tos   = (n > 0) ? m_stk[n-1] : '0;
      e.nos   = (n > 1) ? m_stk[n-2] : '0;
      e.cnt   = CW'(n);
      e.full  = (n == D);
      e.empty = (n == 0);
      e.ovf   = m_ovf;
      e.unf   = m_unf;
      return e;
   endfunction

   // scoreboard: pop one expectation and compare every output field
   task automatic check_outputs(input string tag);
      exp_t e;
      if (exp_q.size() == 0) begin
         n_checks++;
         $error("FAIL %s: expectation queue empty, got 0 entries required 1", tag);
         return;
      end
      e = exp_q.pop_front();
      n_checks++;
      assert (data_out === e.tos) n_pass++;
      else $error("FAIL %s data_out: got %0d required %0d", tag, data_out, e.tos);
      n_checks++;
      assert (next_out === e.nos) n_pass++;
      else $error("FAIL %s next_out: got %0d required %0d", tag, next_out, e.nos);
      n_checks++;
      assert (count === e.cnt) n_pass++;
      else $error("FAIL %s count: got %0d required %0d", tag, count, e.cnt);
      n_checks++;
      assert (full === e.full) n_pass++;
      else $error("FAIL %s full: got %b required %b", tag, full, e.full);
      n_checks++;
      assert (empty === e.empty) n_pass++;
      else $error("FAIL %s empty: got %b required %b", tag, empty, e.empty);
      n_checks++;
      assert (overflow === e.ovf) n_pass++;
      else $error("FAIL %s overflow: got %b required %b", tag, overflow, e.ovf);
      n_checks++;
      assert (underflow === e.unf) n_pass++;
      else $error("FAIL %s underflow: got %b required %b", tag, underflow, e.unf);
   endtask

   // driver: one clock cycle of stimulus followed by its check
   task automatic step(input string tag, input logic r, input logic pu,
                       input logic po, input logic [W-1:0] din, input logic clr);
      @(negedge clk);
      rst       = r;
      push      = pu;
      pop       = po;
      data_in   = din;
      clear_err = clr;
      model_apply(r, pu, po, din, clr);
      exp_q.push_back(model_expect());
      @(posedge clk);
      #1;
      check_outputs(tag);
   endtask

   // directed value check against a constant taken from a worked example
   task automatic check_val(input string tag, input logic [W-1:0] got,
                            input logic [W-1:0] req);
      n_checks++;
      assert (got === req) n_pass++;
      else $error("FAIL %s: got %0d required %0d", tag, got, req);
   endtask

   initial begin
      n_checks  = 0;
      n_pass    = 0;
      m_ovf     = 1'b0;
      m_unf     = 1'b0;
      rst       = 1'b1;
      push      = 1'b0;
      pop       = 1'b0;
      data_in   = '0;
      clear_err = 1'b0;

      // reset state
      step("reset", 1, 0, 0, 0, 0);

      // push 5,7,9 then pop
      step("push5", 0, 1, 0, 5, 0);
      step("push7", 0, 1, 0, 7, 0);
      step("push9", 0, 1, 0, 9, 0);
      check_val("ex1_tos", data_out, 9);
      check_val("ex1_nos", next_out, 7);
      step("pop9", 0, 0, 1, 0, 0);
      check_val("ex1_pop_tos", data_out, 7);
      check_val("ex1_pop_nos", next_out, 5);

      // fill to DEPTH, then overflow
      step("rst2", 1, 0, 0, 0, 0);
      for (int i = 1; i <= D; i++) step("fill", 0, 1, 0, W'(i), 0);
      check_val("fill_tos", data_out, D);
      step("push_full", 0, 1, 0, 99, 0);
      check_val("ovf_tos", data_out, D);
      check_val("ovf_cnt", W'(count), D);
      step("repl_full", 0, 1, 1, 123, 0);
      step("clr_ovf", 0, 0, 0, 0, 1);

      // drain through stored entries, exercising NOS reload from the array
      for (int i = 0; i < D; i++) step("drain", 0, 0, 1, W'($urandom), 0);
      step("pop_empty", 0, 0, 1, 0, 0);
      check_val("unf_tos", data_out, 0);
      step("clr_unf", 0, 0, 0, 0, 1);
      step("clr_and_unf", 0, 0, 1, 0, 1);
      step("clr_unf2", 0, 0, 0, 0, 1);

      // replace TOS: [3,4] push 11 with pop
      step("push3", 0, 1, 0, 3, 0);
      step("push4", 0, 1, 0, 4, 0);
      step("repl11", 0, 1, 1, 11, 0);
      check_val("repl_tos", data_out, 11);
      check_val("repl_nos", next_out, 3);

      // reset with a push on a 10-word stack, then push 2
      for (int i = 0; i < 8; i++) step("grow10", 0, 1, 0, W'(100 + i), 0);
      step("rst_push", 1, 1, 0, 1, 0);
      step("push2", 0, 1, 0, 2, 0);
      check_val("after_rst_tos", data_out, 2);

      // push+pop from empty: push taken, underflow set
      step("rst3", 1, 0, 0, 0, 0);
      step("pp_empty", 0, 1, 1, 6, 0);
      check_val("pp_empty_tos", data_out, 6);

      // random traffic, biased so the stack reaches both ends
      for (int i = 0; i < 400; i++) begin
         logic pu;
         logic po;
         logic clr;
         int   bias;
         bias = (i / 100) % 2;
         pu   = ($urandom_range(0, 9) < (bias ? 7 : 3));
         po   = ($urandom_range(0, 9) < (bias ? 3 : 7));
         clr  = ($urandom_range(0, 15) == 0);
         step("random", ($urandom_range(0, 199) == 0), pu, po, W'($urandom), clr);
      end

      if (exp_q.size() != 0) begin
         n_checks++;
         $error("FAIL leftover: got %0d queued entries required 0", exp_q.size());
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/operand_stack.md
OPERAND_STACK -- requirements
Module: operand_stack

Interface
REQ-001 SHALL provide parameter WIDTH_DATA, default 32, data word width in bits.
REQ-002 SHALL provide parameter DEPTH, default 32, maximum number of stored words; power of two, >= 4.
REQ-003 SHALL provide port clk  input  1  clock; all state changes on rising edge.
REQ-004 SHALL provide port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL provide port push  input  1  write data_in as new top-of-stack this cycle.
REQ-006 SHALL provide port pop  input  1  remove top-of-stack this cycle.
REQ-007 SHALL provide port data_in  input  WIDTH_DATA  word to push.
REQ-008 SHALL provide port clear_err  input  1  clears sticky error flags.
REQ-009 SHALL provide port data_out  output  WIDTH_DATA  current top-of-stack (TOS), registered.
REQ-010 SHALL provide port next_out  output  WIDTH_DATA  element below TOS (NOS), registered.
REQ-011 SHALL provide port count  output  $clog2(DEPTH)+1  number of stored words.
REQ-012 SHALL provide port full  output  1  count == DEPTH.
REQ-013 SHALL provide port empty  output  1  count == 0.
REQ-014 SHALL provide port overflow  output  1  sticky: push rejected because full.
REQ-015 SHALL provide port underflow  output  1  sticky: pop rejected because empty.

Function
REQ-016 SHALL store words in a DEPTH-entry array indexed by a stack pointer sp equal to count; TOS at sp-1, NOS at sp-2.
REQ-017 SHALL keep data_out and next_out valid continuously so the caller samples TOS in the same cycle it asserts pop (read-before-pop).
REQ-018 SHALL update data_out, next_out, count, full, empty in the cycle after the edge that accepts the operation (1-cycle latency).
REQ-019 SHALL, on push only with count < DEPTH: write data_in at sp, count+1, data_out = data_in, next_out = previous data_out.
REQ-020 SHALL, on pop only with count > 0: count-1, data_out = previous next_out, next_out = array[sp-3] (0 if count-1 < 2).
REQ-021 SHALL, on push and pop together with count > 0 (including full): replace TOS with data_in, count unchanged, next_out unchanged, no error.
REQ-022 SHALL, on push and pop together with count == 0: perform push only and set underflow.
REQ-023 SHALL, on push only with count == DEPTH: leave contents, count and outputs unchanged and set overflow.
REQ-024 SHALL, on pop only with count == 0: leave state unchanged and set underflow.
REQ-025 SHALL drive data_out = 0 when empty and next_out = 0 when count < 2.
REQ-026 SHALL hold overflow/underflow until clear_err or rst; if clear_err coincides with a new error, the flag SHALL be set (set wins).
REQ-027 SHALL not wrap the pointer; count SHALL remain within 0..DEPTH under all inputs.
REQ-028 SHALL ignore data_in when push is low.

Reset
REQ-029 SHALL, while rst is high at a clock edge, set count = 0, empty = 1, full = 0, data_out = 0, next_out = 0, overflow = 0, underflow = 0, ignoring push/pop/clear_err in that cycle.
REQ-030 SHALL not require clearing of array contents on reset; stale entries SHALL never appear on data_out or next_out.
REQ-031 SHALL abandon any in-progress operation on reset; the first accepted operation after rst deasserts is the first push/pop sampled at the following edge.

Verification
REQ-032 SHALL pass: reset, push 5, push 7, push 9 -> data_out 9, next_out 7, count 3; pop -> data_out 7, next_out 5, count 2.
REQ-033 SHALL pass: DEPTH pushes of values 1..DEPTH -> full 1, data_out DEPTH; one more push of 99 -> overflow 1, data_out DEPTH, count DEPTH.
REQ-034 SHALL pass: from empty, pop -> underflow 1, count 0, data_out 0; clear_err -> underflow 0.
REQ-035 SHALL pass: stack [3,4] (TOS 4), push 11 with pop -> data_out 11, next_out 3, count 2, no flags.
REQ-036 SHALL pass: stack of 10 words, rst asserted with push 1 -> count 0, empty 1, all outputs 0 next cycle; then push 2 -> data_out 2, count 1.
REQ-037 SHALL pass: from empty, push 6 with pop -> data_out 6, count 1, underflow 1.
